packet_sink_rx: RTL and testbench

- Synthesizable, parametrised successor to the behavioural NoC packet sink.
- Listens on one router output channel and deserialises fixed-length packets (header flit plus payload flits) into a parallel packet word.
- Returns one credit per received packet.
- Maintains packet/error statistics, a completion timestamp and serial-sequence checking.
- Usable in silicon-side test harnesses as well as benches.

---
 rtl/packet_sink_rx_pkg.sv | 29 ++
 rtl/packet_sink_rx_flit_deserializer.sv | 72 +++++++
 rtl/packet_sink_rx.sv | 115 +++++++++++
 tb/tb_packet_sink_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/packet_sink_rx_pkg.sv
// Shared types and constants for the NoC packet sink: FSM encoding, default
// geometry and packet-field offset helpers.
package packet_sink_rx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  localparam int unsigned DEF_CHANNEL_WIDTH = 32;
  localparam int unsigned PKT_FLITS         = 5;
  localparam int unsigned DEF_SERIAL_WIDTH  = 18;
  localparam int unsigned DEF_COUNT_WIDTH   = 32;
  localparam int unsigned DEF_STAMP_WIDTH   = 32;

  // Header flit occupies the MSBs of the packed word, last flit the LSBs.
  function automatic int unsigned packet_bits(int unsigned width, int unsigned flits);
    return width * flits;
  endfunction

  function automatic int unsigned header_lsb(int unsigned width, int unsigned flits);
    return width * (flits - 1);
  endfunction

  function automatic int unsigned flit_cnt_width(int unsigned flits);
    return (flits < 2) ? 1 : $clog2(flits);
  endfunction

endpackage

// File: rtl/packet_sink_rx_flit_deserializer.sv
// Header-triggered flit deserializer: shift register, flit counter and FSM.
// Flags the edge that captures the last flit and registers the packed packet.
module packet_sink_rx_flit_deserializer
  import packet_sink_rx_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH    = DEF_CHANNEL_WIDTH,
  parameter int unsigned FLITS_PER_PACKET = PKT_FLITS,
  parameter int unsigned SERIAL_WIDTH     = DEF_SERIAL_WIDTH
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [CHANNEL_WIDTH-1:0]                    flit_i,
  output logic                                        last_beat_o,
  output logic [SERIAL_WIDTH-1:0]                     beat_serial_o,
  output logic                                        done_o,
  output logic [CHANNEL_WIDTH*FLITS_PER_PACKET-1:0]   word_o
);

  localparam int unsigned PW    = packet_bits(CHANNEL_WIDTH, FLITS_PER_PACKET);
  localparam int unsigned SHW   = header_lsb(CHANNEL_WIDTH, FLITS_PER_PACKET);
  localparam int unsigned CNT_W = flit_cnt_width(FLITS_PER_PACKET);

  rx_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SHW-1:0]     shift_q;
  logic [SHW-1:0]     shift_d;
  logic [PW-1:0]      shift_wide;
  logic               done_q;
  logic [PW-1:0]      word_q;

  // Only the flits preceding the last one are buffered; the last is merged on the fly.
  assign shift_wide    = {shift_q, flit_i};
  assign shift_d       = shift_wide[SHW-1:0];
  assign last_beat_o   = (state_q == ST_RECV) && (cnt_q == CNT_W'(FLITS_PER_PACKET - 1));
  assign beat_serial_o = shift_q[SHW-CHANNEL_WIDTH +: SERIAL_WIDTH];
  assign done_o        = done_q;
  assign word_o        = word_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flit_i != '0) begin
            shift_q <= shift_d;
            cnt_q   <= CNT_W'(1);
            state_q <= ST_RECV;
          end
        end
        ST_RECV: begin
          // Payload flits are captured even when zero; only IDLE treats zero as no traffic.
          shift_q <= shift_d;
          if (last_beat_o) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            word_q  <= shift_wide;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/packet_sink_rx.sv
// NoC packet sink: deserialises fixed-length packets, returns one credit per
// packet, and keeps counts, a completion timestamp and serial-sequence checks.
module packet_sink_rx
  import packet_sink_rx_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH    = DEF_CHANNEL_WIDTH,
  parameter int unsigned FLITS_PER_PACKET = PKT_FLITS,
  parameter int unsigned SERIAL_WIDTH     = DEF_SERIAL_WIDTH,
  parameter int unsigned COUNT_WIDTH      = DEF_COUNT_WIDTH,
  parameter int unsigned STAMP_WIDTH      = DEF_STAMP_WIDTH,
  parameter bit          CHECK_SERIAL     = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [CHANNEL_WIDTH-1:0]                   channel_in,
  output logic                                       credit_out,
  output logic                                       packet_valid,
  output logic [CHANNEL_WIDTH*FLITS_PER_PACKET-1:0]  packet_data,
  output logic [SERIAL_WIDTH-1:0]                    packet_serial,
  output logic [STAMP_WIDTH-1:0]                     rx_stamp,
  output logic [COUNT_WIDTH-1:0]                     packet_count,
  output logic                                       serial_error,
  output logic [COUNT_WIDTH-1:0]                     error_count
);

  logic                    last_beat;
  logic [SERIAL_WIDTH-1:0] beat_serial;
  logic                    done;
  logic [STAMP_WIDTH-1:0]  cycle_q;
  logic [STAMP_WIDTH-1:0]  stamp_q;
  logic [SERIAL_WIDTH-1:0] serial_q;
  logic [COUNT_WIDTH-1:0]  count_q;

  packet_sink_rx_flit_deserializer #(
    .CHANNEL_WIDTH    (CHANNEL_WIDTH),
    .FLITS_PER_PACKET (FLITS_PER_PACKET),
    .SERIAL_WIDTH     (SERIAL_WIDTH)
  ) u_deser (
    .clk_i         (clk),
    .reset_i       (reset),
    .flit_i        (channel_in),
    .last_beat_o   (last_beat),
    .beat_serial_o (beat_serial),
    .done_o        (done),
    .word_o        (packet_data)
  );

  // Credit and valid share the deserializer's registered completion pulse.
  assign packet_valid  = done;
  assign credit_out    = done;
  assign packet_serial = serial_q;
  assign rx_stamp      = stamp_q;
  assign packet_count  = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + STAMP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q  <= '0;
      serial_q <= '0;
      count_q  <= '0;
    end else if (last_beat) begin
      stamp_q  <= cycle_q;
      serial_q <= beat_serial;
      if (count_q != '1) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  generate
    if (CHECK_SERIAL) begin : g_check
      logic [SERIAL_WIDTH-1:0] expect_q;
      logic                    expect_valid_q;
      logic                    serr_q;
      logic [COUNT_WIDTH-1:0]  err_q;
      logic                    mismatch;

      // The first packet after reset only seeds the expected serial.
      assign mismatch = expect_valid_q && (beat_serial != expect_q);

      always_ff @(posedge clk) begin
        if (reset) begin
          expect_q       <= '0;
          expect_valid_q <= 1'b0;
          serr_q         <= 1'b0;
          err_q          <= '0;
        end else begin
          serr_q <= 1'b0;
          if (last_beat) begin
            serr_q         <= mismatch;
            expect_valid_q <= 1'b1;
            expect_q       <= beat_serial + SERIAL_WIDTH'(1);
            if (mismatch && (err_q != '1)) begin
              err_q <= err_q + COUNT_WIDTH'(1);
            end
          end
        end
      end

      assign serial_error = serr_q;
      assign error_count  = err_q;
    end else begin : g_nocheck
      assign serial_error = 1'b0;
      assign error_count  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_packet_sink_rx.sv
// Randomized and directed bench for packet_sink_rx against a packet-level
// reference model (whole packets in, expected completions out).
module tb_packet_sink_rx;

  localparam int W   = 32;
  localparam int FPP = 5;
  localparam int SW  = 18;
  localparam int CW  = 32;
  localparam int STW = 32;
  localparam int PW  = W * FPP;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   channel_in;
  logic           credit_out;
  logic           packet_valid;
  logic [PW-1:0]  packet_data;
  logic [SW-1:0]  packet_serial;
  logic [STW-1:0] rx_stamp;
  logic [CW-1:0]  packet_count;
  logic           serial_error;
  logic [CW-1:0]  error_count;

  packet_sink_rx dut (
    .clk           (clk),
    .reset         (reset),
    .channel_in    (channel_in),
    .credit_out    (credit_out),
    .packet_valid  (packet_valid),
    .packet_data   (packet_data),
    .packet_serial (packet_serial),
    .rx_stamp      (rx_stamp),
    .packet_count  (packet_count),
    .serial_error  (serial_error),
    .error_count   (error_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PW-1:0]  m_data;
  logic [SW-1:0]  m_serial;
  logic [STW-1:0] m_stamp;
  logic [CW-1:0]  m_count;
  logic [CW-1:0]  m_errs;
  logic [SW-1:0]  m_exp;
  bit             m_seen;
  bit             m_pulse;
  bit             m_serr;
  int             cyc;
  logic [W-1:0]   flits [FPP];

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("valid",     PW'(packet_valid),  PW'(m_pulse));
    check("credit",    PW'(credit_out),    PW'(m_pulse));
    check("serr",      PW'(serial_error),  PW'(m_serr));
    check("data",      packet_data,        m_data);
    check("serial",    PW'(packet_serial), PW'(m_serial));
    check("stamp",     PW'(rx_stamp),      PW'(m_stamp));
    check("count",     PW'(packet_count),  PW'(m_count));
    check("err_count", PW'(error_count),   PW'(m_errs));
  endtask

  task automatic model_clear();
    m_data = '0; m_serial = '0; m_stamp = '0; m_count = '0; m_errs = '0;
    m_exp = '0; m_seen = 0; m_pulse = 0; m_serr = 0;
  endtask

  // Completion rules applied to the packet currently held in flits[].
  task automatic model_complete();
    logic [SW-1:0] s;
    logic [W-1:0]  hdr;
    m_data = '0;
    for (int i = 0; i < FPP; i++) m_data = (m_data << W) | PW'(flits[i]);
    hdr = flits[0];
    s = hdr[SW-1:0];
    m_serial = s;
    m_stamp  = STW'(cyc);
    if (m_count != '1) m_count = m_count + CW'(1);
    m_pulse = 1;
    if (m_seen && (s != m_exp)) begin
      m_serr = 1;
      if (m_errs != '1) m_errs = m_errs + CW'(1);
    end
    m_seen = 1;
    m_exp  = s + SW'(1);
  endtask

  task automatic tick(input logic [W-1:0] flit, input bit last);
    channel_in = flit;
    @(posedge clk);
    m_pulse = 0;
    m_serr  = 0;
    if (last) model_complete();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 0);
  endtask

  task automatic send_packet();
    for (int i = 0; i < FPP; i++) tick(flits[i], i == FPP - 1);
    $display("packet serial=%0h count=%0d errs=%0d stamp=%0d", m_serial, m_count, m_errs, m_stamp);
  endtask

  task automatic set_pkt(input logic [W-1:0] hdr, input logic [W-1:0] base);
    flits[0] = hdr;
    for (int i = 1; i < FPP; i++) flits[i] = base + W'(i);
  endtask

  // Two reset edges; the first samples 'flit' so a coincident completion is exercised.
  task automatic do_reset(input logic [W-1:0] flit);
    reset = 1'b1;
    channel_in = flit;
    @(posedge clk);
    channel_in = '0;
    @(posedge clk);
    #1;
    model_clear();
    check_outputs();
    reset = 1'b0;
    cyc = 0;
    $display("reset done");
  endtask

  initial begin
    logic [SW-1:0] s;
    logic [W-1:0]  hdr;
    reset = 1'b1;
    channel_in = '0;
    model_clear();
    cyc = 0;

    // Basic packet, header at edge 10
    do_reset('0);
    idle(10);
    flits[0] = 32'h7; flits[1] = 32'hA1; flits[2] = 32'hA2; flits[3] = 32'hA3; flits[4] = 32'hA4;
    send_packet();
    check("tp1_data",  packet_data, 160'h00000007_000000A1_000000A2_000000A3_000000A4);
    check("tp1_stamp", PW'(rx_stamp), PW'(14));
    check("tp1_count", PW'(packet_count), PW'(1));
    idle(2);

    // Back-to-back serials 1,2,3
    do_reset('0);
    for (int k = 1; k <= 3; k++) begin
      set_pkt(W'(k), W'(32'h100 * k));
      send_packet();
    end
    check("b2b_count", PW'(packet_count), PW'(3));
    check("b2b_errs",  PW'(error_count), PW'(0));
    idle(3);

    // Serials 4, 6, 7
    do_reset('0);
    set_pkt(32'h4, 32'h40); send_packet();
    set_pkt(32'h6, 32'h60); send_packet();
    check("seq_err", PW'(error_count), PW'(1));
    set_pkt(32'h7, 32'h70); send_packet();
    check("seq_err_after", PW'(error_count), PW'(1));
    idle(1);

    // Serial wrap 0x3FFFF -> 0 (header kept nonzero via bit SW)
    do_reset('0);
    set_pkt(32'h0003FFFF, 32'h11); send_packet();
    set_pkt(32'h00040000, 32'h22); send_packet();
    check("wrap_errs",   PW'(error_count), PW'(0));
    check("wrap_serial", PW'(packet_serial), PW'(0));

    // Reset mid-packet, then a full packet
    do_reset('0);
    set_pkt(32'h9, 32'h90);
    for (int i = 0; i < 3; i++) tick(flits[i], 0);
    do_reset('0);
    set_pkt(32'hA, 32'hB0); send_packet();
    check("midrst_count", PW'(packet_count), PW'(1));
    check("midrst_data",  packet_data, 160'h0000000A_000000B1_000000B2_000000B3_000000B4);

    // Zero payload flits
    do_reset('0);
    flits[0] = 32'h55;
    for (int i = 1; i < FPP; i++) flits[i] = '0;
    send_packet();
    check("zero_data", packet_data, 160'h00000055_00000000_00000000_00000000_00000000);
    check("zero_count", PW'(packet_count), PW'(1));

    // Reset coincident with the last-flit edge
    set_pkt(32'h56, 32'h300);
    for (int i = 0; i < FPP - 1; i++) tick(flits[i], 0);
    do_reset(flits[FPP-1]);
    check("rst_last_count", PW'(packet_count), PW'(0));

    // Randomized traffic
    for (int p = 0; p < 60; p++) begin
      if (!m_seen || ($urandom_range(0, 3) == 0)) s = SW'($urandom);
      else s = m_exp;
      hdr = $urandom;
      hdr[SW-1:0] = s;
      if (hdr == '0) hdr = W'(1) << SW;
      flits[0] = hdr;
      for (int i = 1; i < FPP; i++) flits[i] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      idle($urandom_range(0, 2));
      send_packet();
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
